// File: rtl/multi_port_reg_file_if.sv
// Bus bundle for the two-write / two-read register file.
// master = requester side, slave = register file side.
interface multi_port_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wrEn0;
    logic [ADDR_W-1:0] wrAddr0;
    logic [DATA_W-1:0] wrData0;
    logic              wrEn1;
    logic [ADDR_W-1:0] wrAddr1;
    logic [DATA_W-1:0] wrData1;
    logic              reEn1;
    logic [ADDR_W-1:0] reReg1;
    logic [DATA_W-1:0] reData1;
    logic              reEn2;
    logic [ADDR_W-1:0] reReg2;
    logic [DATA_W-1:0] reData2;
    logic              wrConflict;

    modport master (
        output wrEn0, wrAddr0, wrData0,
        output wrEn1, wrAddr1, wrData1,
        output reEn1, reReg1,
        output reEn2, reReg2,
        input  reData1, reData2, wrConflict
    );

    modport slave (
        input  wrEn0, wrAddr0, wrData0,
        input  wrEn1, wrAddr1, wrData1,
        input  reEn1, reReg1,
        input  reEn2, reReg2,
        output reData1, reData2, wrConflict
    );
endinterface

// File: rtl/multi_port_reg_file.sv
// Two-write, two-read register file with registered read data.
// Define MULTI_PORT_REG_FILE_BYPASS_EN to forward same-cycle write data to reads.
module multi_port_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_port_reg_file_if.slave    bus
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_conflict;

    logic              w_wr0_ok;
    logic              w_wr1_ok;
    logic              w_conflict;
    logic [DATA_W-1:0] w_rd1_val;
    logic [DATA_W-1:0] w_rd2_val;

    // Qualify write enables; hardwired register 0 swallows its writes
    always_comb begin
        w_wr0_ok   = bus.wrEn0 && !(ZERO_EN && bus.wrAddr0 == '0);
        w_wr1_ok   = bus.wrEn1 && !(ZERO_EN && bus.wrAddr1 == '0);
        w_conflict = w_wr0_ok && w_wr1_ok
                   && (bus.wrAddr0 == bus.wrAddr1);
    end

    // Read port 1 value: storage, optional forwarding, zero override
    always_comb begin
        w_rd1_val = r_regs[bus.reReg1];
`ifdef MULTI_PORT_REG_FILE_BYPASS_EN
        if (w_wr0_ok && bus.wrAddr0 == bus.reReg1)
            w_rd1_val = bus.wrData0;
        if (w_wr1_ok && bus.wrAddr1 == bus.reReg1)
            w_rd1_val = bus.wrData1;
`endif
        if (ZERO_EN && bus.reReg1 == '0)
            w_rd1_val = '0;
    end

    // Read port 2 value: storage, optional forwarding, zero override
    always_comb begin
        w_rd2_val = r_regs[bus.reReg2];
`ifdef MULTI_PORT_REG_FILE_BYPASS_EN
        if (w_wr0_ok && bus.wrAddr0 == bus.reReg2)
            w_rd2_val = bus.wrData0;
        if (w_wr1_ok && bus.wrAddr1 == bus.reReg2)
            w_rd2_val = bus.wrData1;
`endif
        if (ZERO_EN && bus.reReg2 == '0)
            w_rd2_val = '0;
    end

    // Storage update; on a same-address collision port 1 wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else begin
            if (w_wr0_ok && !w_conflict)
                r_regs[bus.wrAddr0] <= bus.wrData0;
            if (w_wr1_ok)
                r_regs[bus.wrAddr1] <= bus.wrData1;
        end
    end

    // Registered read data, held while the port is not enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else begin
            if (bus.reEn1)
                r_rd1 <= w_rd1_val;
            if (bus.reEn2)
                r_rd2 <= w_rd2_val;
        end
    end

    // Collision flag, valid for the cycle after the colliding writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_conflict <= 1'b0;
        else
            r_conflict <= w_conflict;
    end

    assign bus.reData1    = r_rd1;
    assign bus.reData2    = r_rd2;
    assign bus.wrConflict = r_conflict;
endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed bench for multi_port_reg_file with an array-based reference model.
// Build with or without MULTI_PORT_REG_FILE_BYPASS_EN; the model follows.
module tb_multi_port_reg_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;

    logic [31:0] mem [32];
    logic [31:0] m_rd1 = '0;
    logic [31:0] m_rd2 = '0;
    logic        m_conf = 1'b0;

    multi_port_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    multi_port_reg_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_reData1", bus.reData1, m_rd1);
            chk("cyc_reData2", bus.reData2, m_rd2);
            chk("cyc_wrConflict", {31'b0, bus.wrConflict}, {31'b0, m_conf});
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef MULTI_PORT_REG_FILE_BYPASS_EN
        if (bus.wrEn1 && bus.wrAddr1 == a) return bus.wrData1;
        if (bus.wrEn0 && bus.wrAddr0 == a) return bus.wrData0;
`endif
        return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        m_rd1 = '0;
        m_rd2 = '0;
        m_conf = 1'b0;
    endtask

    // One clock: compute model next state from current inputs, then advance
    task automatic tick();
        logic [31:0] n1, n2;
        logic        nc;
        n1 = bus.reEn1 ? model_read(bus.reReg1) : m_rd1;
        n2 = bus.reEn2 ? model_read(bus.reReg2) : m_rd2;
        nc = bus.wrEn0 && bus.wrEn1 && bus.wrAddr0 == bus.wrAddr1
             && bus.wrAddr0 != 5'd0;
        @(posedge clk);
        if (!rst) begin
            if (bus.wrEn0 && bus.wrAddr0 != 5'd0) mem[bus.wrAddr0] = bus.wrData0;
            if (bus.wrEn1 && bus.wrAddr1 != 5'd0) mem[bus.wrAddr1] = bus.wrData1;
            m_rd1 = n1;
            m_rd2 = n2;
            m_conf = nc;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wrEn0 = 0; bus.wrAddr0 = '0; bus.wrData0 = '0;
        bus.wrEn1 = 0; bus.wrAddr1 = '0; bus.wrData1 = '0;
        bus.reEn1 = 0; bus.reReg1 = '0;
        bus.reEn2 = 0; bus.reReg2 = '0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        bus.wrEn0 = 1; bus.wrAddr0 = a; bus.wrData0 = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        bus.wrEn1 = 1; bus.wrAddr1 = a; bus.wrData1 = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.reEn1 = 1; bus.reReg1 = a1;
        bus.reEn2 = 1; bus.reReg2 = a2;
    endtask

    initial begin
        idle();
        model_clear();
        @(negedge clk);
        chk("reset_reData1", bus.reData1, 32'h0);
        chk("reset_reData2", bus.reData2, 32'h0);
        chk("reset_wrConflict", {31'b0, bus.wrConflict}, 32'h0);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // Reset clears mid-cycle
        idle(); wr0(5'd7, 32'hDEADBEEF); tick();
        idle(); rd(5'd7, 5'd7); tick();
        chk("pre_rst_rd7", bus.reData1, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_reData1", bus.reData1, 32'h0);
        chk("async_rst_reData2", bus.reData2, 32'h0);
        model_clear();
        idle(); wr0(5'd7, 32'h12345678); rd(5'd7, 5'd7); tick();
        rst = 1'b0;
        idle(); rd(5'd7, 5'd7); tick();
        chk("post_rst_rd7", bus.reData2, 32'h0);

        // Dual write to distinct addresses
        idle(); wr0(5'd3, 32'h11); wr1(5'd4, 32'h22); tick();
        chk("dual_no_conflict", {31'b0, bus.wrConflict}, 32'h0);
        idle(); rd(5'd3, 5'd4); tick();
        chk("dual_rd3", bus.reData1, 32'h11);
        chk("dual_rd4", bus.reData2, 32'h22);

        // Hold while reEn1 low
        idle(); bus.reEn1 = 0; wr0(5'd3, 32'h99); tick();
        chk("hold_1", bus.reData1, 32'h11);
        idle(); tick();
        chk("hold_2", bus.reData1, 32'h11);
        idle(); rd(5'd3, 5'd3); tick();
        chk("hold_reread", bus.reData1, 32'h99);

        // Same-address conflict, port 1 wins
        idle(); wr0(5'd9, 32'hAAAA); wr1(5'd9, 32'h5555); tick();
        chk("conflict_flag", {31'b0, bus.wrConflict}, 32'h1);
        idle(); rd(5'd9, 5'd9); tick();
        chk("conflict_clear", {31'b0, bus.wrConflict}, 32'h0);
        chk("conflict_rd9", bus.reData1, 32'h5555);

        // Zero register
        idle(); wr0(5'd0, 32'hFFFFFFFF); wr1(5'd0, 32'h1); rd(5'd0, 5'd0); tick();
        chk("zero_no_conflict", {31'b0, bus.wrConflict}, 32'h0);
        chk("zero_bypass_rd", bus.reData1, 32'h0);
        idle(); rd(5'd0, 5'd0); tick();
        chk("zero_rd0", bus.reData2, 32'h0);

        // Forwarding of same-cycle write
        idle(); wr0(5'd5, 32'h1); tick();
        idle(); wr0(5'd5, 32'h2); rd(5'd5, 5'd5); tick();
`ifdef MULTI_PORT_REG_FILE_BYPASS_EN
        chk("bypass_rd5", bus.reData1, 32'h2);
`else
        chk("bypass_rd5", bus.reData1, 32'h1);
`endif
        idle(); rd(5'd5, 5'd9); tick();
        chk("after_bypass_rd5", bus.reData1, 32'h2);

        // Both ports colliding while being read
        idle(); wr0(5'd10, 32'hA0A0A0A0); wr1(5'd10, 32'hB1B1B1B1);
        rd(5'd10, 5'd10); tick();
        idle(); rd(5'd10, 5'd10); tick();
        chk("collide_rd10", bus.reData2, 32'hB1B1B1B1);

        // Top-of-range addresses
        idle(); wr0(5'd31, 32'hCAFEF00D); wr1(5'd30, 32'h0BADC0DE); tick();
        idle(); rd(5'd31, 5'd30); tick();
        chk("top_rd31", bus.reData1, 32'hCAFEF00D);
        chk("top_rd30", bus.reData2, 32'h0BADC0DE);

        // Port 1 overwrite bypass priority with distinct-port mix
        idle(); wr0(5'd12, 32'h12); wr1(5'd13, 32'h13); rd(5'd13, 5'd12); tick();
        idle(); rd(5'd12, 5'd13); tick();
        chk("mix_rd12", bus.reData1, 32'h12);
        chk("mix_rd13", bus.reData2, 32'h13);

        idle(); tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_port_reg_file.md
MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

Interface
REQ-001 Parameters SHALL be:
  DATA_W, 32, register and data width in bits
  ADDR_W, 5, address width; depth = 2**ADDR_W registers
  ZERO_REG, 1, 1 = register 0 hardwired to zero, 0 = register 0 ordinary
REQ-002 Ports SHALL be:
  clk  input  1  single clock, all state updates on rising edge
  rst  input  1  asynchronous, active-high reset
  wrEn0  input  1  write port 0 enable
  wrAddr0  input  ADDR_W  write port 0 address
  wrData0  input  DATA_W  write port 0 data
  wrEn1  input  1  write port 1 enable
  wrAddr1  input  ADDR_W  write port 1 address
  wrData1  input  DATA_W  write port 1 data
  reEn1  input  1  read port 1 enable
  reReg1  input  ADDR_W  read port 1 address
  reData1  output  DATA_W  read port 1 data, registered
  reEn2  input  1  read port 2 enable
  reReg2  input  ADDR_W  read port 2 address
  reData2  output  DATA_W  read port 2 data, registered
  wrConflict  output  1  registered flag: both write ports hit the same address this cycle

Function
REQ-003 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-004 Writes SHALL commit at the rising clk edge when the port's wrEn is 1; both ports SHALL be able to write different addresses in the same cycle.
REQ-005 If wrEn0 = wrEn1 = 1 and wrAddr0 = wrAddr1, only wrData1 SHALL be stored (port 1 wins), and wrConflict SHALL be 1 in the following cycle; otherwise wrConflict SHALL be 0.
REQ-006 Reads SHALL have a 1-cycle latency: when reEnK = 1 at edge N, reDataK SHALL show the selected value from edge N until the next enabled read.
REQ-007 When reEnK = 0, reDataK SHALL hold its previous value.
REQ-008 When ZERO_REG = 1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and such a write SHALL neither raise wrConflict nor be bypassed.
REQ-009 With bypass compiled in, a read whose address matches a same-cycle enabled write SHALL return the write data (port 1 data if both ports match); with bypass compiled out, it SHALL return the pre-write register content.
REQ-010 Address decode SHALL use all ADDR_W bits; there are no out-of-range addresses.
REQ-011 Read ports SHALL be fully independent; both SHALL be able to read the same address in the same cycle.

Reset
REQ-012 Asserting rst SHALL immediately, without waiting for clk, clear every register, reData1, reData2 and wrConflict to 0.
REQ-013 While rst = 1, writes and reads SHALL be ignored.
REQ-014 The first edge after rst deasserts SHALL operate normally.
REQ-015 A write coinciding with rst assertion SHALL be lost.

Configuration
REQ-016 Macro MULTI_PORT_REG_FILE_BYPASS_EN SHALL select write-to-read forwarding.
  - Defined: reads return same-cycle write data per REQ-009.
  - Undefined: reads return old contents (read-before-write); all other behaviour is unchanged.

Verification
REQ-017 Reset: write 0xDEADBEEF to reg 7, assert rst asynchronously mid-cycle -> reData1/reData2 = 0 immediately; read reg 7 after release -> 0.
REQ-018 Dual write: wrEn0 to reg 3 = 0x11, wrEn1 to reg 4 = 0x22 in one cycle; next cycle read 3 and 4 -> reData1 = 0x11, reData2 = 0x22 one cycle later, wrConflict = 0.
REQ-019 Conflict: both ports write reg 9 (0xAAAA via port 0, 0x5555 via port 1) -> wrConflict = 1 next cycle; later read of reg 9 -> 0x5555.
REQ-020 Zero register (ZERO_REG = 1): write 0xFFFFFFFF to reg 0 -> read of reg 0 returns 0, wrConflict stays 0.
REQ-021 Bypass: reg 5 = 0x1; same cycle write 0x2 to reg 5 and read reg 5 -> reData1 = 0x2 with MULTI_PORT_REG_FILE_BYPASS_EN defined, 0x1 without it.
REQ-022 Hold: read reg 3 (0x11), then deassert reEn1 and write 0x99 to reg 3 -> reData1 stays 0x11 until reEn1 is reasserted.
